// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, mispredict detection and statistics
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  fetchPC,
  output logic             predTaken,
  output logic [XLEN-1:0]  predTarget,
  input  logic             updValid,
  input  logic [XLEN-1:0]  updPC,
  input  logic             updIsJump,
  input  logic             updTaken,
  input  logic [XLEN-1:0]  updTarget,
  input  logic             updPredTaken,
  input  logic [XLEN-1:0]  updPredTarget,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirectPC,
  output logic [CNT_W-1:0] branchCount,
  output logic [CNT_W-1:0] mispredictCount
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  logic             r_valid  [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]  r_target [ENTRIES];
  logic [CNT_W-1:0] r_bcnt, r_mcnt;
  logic             r_mis;
  logic [XLEN-1:0]  r_redirect;
  logic [IDX_W-1:0] w_fidx, w_uidx;
  logic [TAG_W-1:0] w_ftag, w_utag;
  logic             w_fhit, w_uhit, w_mis, w_we, w_twe;
  logic [1:0]       w_uctr, w_ctr_nxt;
  assign w_fidx = fetchPC[IDX_W+1:2];
  assign w_ftag = fetchPC[XLEN-1:IDX_W+2];
  assign w_uidx = updPC[IDX_W+1:2];
  assign w_utag = updPC[XLEN-1:IDX_W+2];
  assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_uctr = r_ctr[w_uidx];
  assign predTaken  = w_fhit && r_ctr[w_fidx][1];
  assign predTarget = predTaken ? r_target[w_fidx] : fetchPC + XLEN'(4);
  assign w_mis = (updPredTaken != updTaken) || (updTaken && (updPredTarget != updTarget));
  // a miss allocates only when taken; a hit always updates its counter
  assign w_we  = updValid && (w_uhit || updTaken);
  assign w_twe = updValid && (updTaken || (w_uhit && updIsJump));
  // counter next state: jumps pin strong-taken, fresh branches start weak-taken
  always_comb begin
    w_ctr_nxt = updIsJump ? 2'b11 :
                !w_uhit   ? 2'b10 :
                updTaken  ? ((w_uctr == 2'b11) ? 2'b11 : w_uctr + 2'b01) :
                            ((w_uctr == 2'b00) ? 2'b00 : w_uctr - 2'b01);
  end
  // valid bits and counters; reset empties the table and drops any concurrent update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (w_we) begin
      r_valid[w_uidx] <= 1'b1;
      r_ctr[w_uidx]   <= w_ctr_nxt;
    end
  end
  // tags and targets need no reset since valid gates their use
  always_ff @(posedge clk) begin
    if (!rst && w_we) r_tag[w_uidx] <= w_utag;
    if (!rst && w_twe) r_target[w_uidx] <= updTarget;
  end
  // registered resolution result; redirect holds across idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mis      <= 1'b0;
      r_redirect <= '0;
    end else begin
      r_mis <= updValid && w_mis;
      if (updValid) r_redirect <= updTaken ? updTarget : updPC + XLEN'(4);
    end
  end
  // saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcnt <= '0;
      r_mcnt <= '0;
    end else if (updValid) begin
      r_bcnt <= r_bcnt + CNT_W'(r_bcnt != '1);
      r_mcnt <= r_mcnt + CNT_W'(w_mis && (r_mcnt != '1));
    end
  end
  assign mispredict      = r_mis;
  assign redirectPC      = r_redirect;
  assign branchCount     = r_bcnt;
  assign mispredictCount = r_mcnt;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of lookup, training, aliasing, mispredict and saturation
module tb_branch_predictor;
  logic        clk = 0, rst = 1;
  logic [31:0] fetchPC = 0, updPC = 0, updTarget = 0, updPredTarget = 0;
  logic        updValid = 0, updIsJump = 0, updTaken = 0, updPredTaken = 0;
  logic        predTaken, mispredict;
  logic [31:0] predTarget, redirectPC;
  logic [3:0]  branchCount, mispredictCount;
  int n_vec = 0, n_bad = 0;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .fetchPC(fetchPC), .predTaken(predTaken), .predTarget(predTarget),
    .updValid(updValid), .updPC(updPC), .updIsJump(updIsJump), .updTaken(updTaken),
    .updTarget(updTarget), .updPredTaken(updPredTaken), .updPredTarget(updPredTarget),
    .mispredict(mispredict), .redirectPC(redirectPC), .branchCount(branchCount),
    .mispredictCount(mispredictCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic reset_dut();
    @(negedge clk); rst = 1;
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic j, input logic t,
                     input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    @(negedge clk);
    updValid = 1; updPC = pc; updIsJump = j; updTaken = t; updTarget = tgt;
    updPredTaken = pt; updPredTarget = ptgt;
    @(posedge clk); #1; updValid = 0;
  endtask

  task automatic idle();
    @(negedge clk); updValid = 0;
    @(posedge clk); #1;
  endtask

  task automatic look(input logic [31:0] pc);
    fetchPC = pc; #1;
  endtask

  task automatic test_reset();
    reset_dut();
    reset_dut();
    n_vec++; if (mispredict !== 1'b0) begin n_bad++; $display("FAIL rst_mis got %0h exp 0", mispredict); end
    n_vec++; if (redirectPC !== 32'h0) begin n_bad++; $display("FAIL rst_redir got %0h exp 0", redirectPC); end
    n_vec++; if (branchCount !== 4'd0) begin n_bad++; $display("FAIL rst_bcnt got %0d exp 0", branchCount); end
    n_vec++; if (mispredictCount !== 4'd0) begin n_bad++; $display("FAIL rst_mcnt got %0d exp 0", mispredictCount); end
    look(32'h1000);
    n_vec++; if (predTaken !== 1'b0) begin n_bad++; $display("FAIL rst_pt got %0h exp 0", predTaken); end
    n_vec++; if (predTarget !== 32'h1004) begin n_bad++; $display("FAIL rst_ptgt got %0h exp 1004", predTarget); end
    look(32'hFFFF_FFFC);
    n_vec++; if (predTarget !== 32'h0) begin n_bad++; $display("FAIL wrap_ptgt got %0h exp 0", predTarget); end
  endtask

  task automatic test_alloc();
    @(negedge clk);
    updValid = 1; updPC = 32'h1000; updIsJump = 0; updTaken = 1; updTarget = 32'h1010;
    updPredTaken = 0; updPredTarget = 32'h1004;
    fetchPC = 32'h1000; #1;
    n_vec++; if (predTaken !== 1'b0) begin n_bad++; $display("FAIL rbw_pt got %0h exp 0", predTaken); end
    @(posedge clk); #1; updValid = 0;
    n_vec++; if (mispredict !== 1'b1) begin n_bad++; $display("FAIL alloc_mis got %0h exp 1", mispredict); end
    n_vec++; if (redirectPC !== 32'h1010) begin n_bad++; $display("FAIL alloc_redir got %0h exp 1010", redirectPC); end
    n_vec++; if (mispredictCount !== 4'd1) begin n_bad++; $display("FAIL alloc_mcnt got %0d exp 1", mispredictCount); end
    n_vec++; if (branchCount !== 4'd1) begin n_bad++; $display("FAIL alloc_bcnt got %0d exp 1", branchCount); end
    look(32'h1000);
    n_vec++; if (predTaken !== 1'b1) begin n_bad++; $display("FAIL alloc_pt got %0h exp 1", predTaken); end
    n_vec++; if (predTarget !== 32'h1010) begin n_bad++; $display("FAIL alloc_ptgt got %0h exp 1010", predTarget); end
    look(32'h1003);
    n_vec++; if (predTaken !== 1'b1) begin n_bad++; $display("FAIL lowbits_pt got %0h exp 1", predTaken); end
  endtask

  task automatic test_counter();
    upd(32'h1000, 0, 0, 32'h0, 1, 32'h1010);
    n_vec++; if (mispredict !== 1'b1) begin n_bad++; $display("FAIL nt1_mis got %0h exp 1", mispredict); end
    n_vec++; if (redirectPC !== 32'h1004) begin n_bad++; $display("FAIL nt1_redir got %0h exp 1004", redirectPC); end
    look(32'h1000);
    n_vec++; if (predTaken !== 1'b0) begin n_bad++; $display("FAIL nt1_pt got %0h exp 0", predTaken); end
    upd(32'h1000, 0, 0, 32'h0, 0, 32'h1004);
    n_vec++; if (mispredict !== 1'b0) begin n_bad++; $display("FAIL nt2_mis got %0h exp 0", mispredict); end
    upd(32'h1000, 0, 0, 32'h0, 0, 32'h1004);
    look(32'h1000);
    n_vec++; if (predTaken !== 1'b0) begin n_bad++; $display("FAIL nt3_pt got %0h exp 0", predTaken); end
    upd(32'h1000, 0, 1, 32'h1010, 0, 32'h1004);
    look(32'h1000);
    n_vec++; if (predTaken !== 1'b0) begin n_bad++; $display("FAIL t1_pt got %0h exp 0", predTaken); end
    upd(32'h1000, 0, 1, 32'h1010, 0, 32'h1004);
    look(32'h1000);
    n_vec++; if (predTaken !== 1'b1) begin n_bad++; $display("FAIL t2_pt got %0h exp 1", predTaken); end
    n_vec++; if (branchCount !== 4'd6) begin n_bad++; $display("FAIL ctr_bcnt got %0d exp 6", branchCount); end
    n_vec++; if (mispredictCount !== 4'd4) begin n_bad++; $display("FAIL ctr_mcnt got %0d exp 4", mispredictCount); end
  endtask

  task automatic test_jump_alias();
    upd(32'h2000, 1, 1, 32'h3000, 0, 32'h2004);
    look(32'h2000);
    n_vec++; if (predTaken !== 1'b1) begin n_bad++; $display("FAIL jmp_pt got %0h exp 1", predTaken); end
    n_vec++; if (predTarget !== 32'h3000) begin n_bad++; $display("FAIL jmp_ptgt got %0h exp 3000", predTarget); end
    look(32'h1000);
    n_vec++; if (predTaken !== 1'b0) begin n_bad++; $display("FAIL evict_pt got %0h exp 0", predTaken); end
    upd(32'h2040, 0, 1, 32'h5000, 0, 32'h2044);
    look(32'h2000);
    n_vec++; if (predTaken !== 1'b0) begin n_bad++; $display("FAIL alias_pt got %0h exp 0", predTaken); end
    n_vec++; if (predTarget !== 32'h2004) begin n_bad++; $display("FAIL alias_ptgt got %0h exp 2004", predTarget); end
    look(32'h2040);
    n_vec++; if (predTarget !== 32'h5000) begin n_bad++; $display("FAIL alias_new got %0h exp 5000", predTarget); end
    upd(32'h2000, 0, 0, 32'h0, 0, 32'h2004);
    look(32'h2040);
    n_vec++; if (predTaken !== 1'b1) begin n_bad++; $display("FAIL missnt_pt got %0h exp 1", predTaken); end
  endtask

  task automatic test_target_mis();
    reset_dut();
    upd(32'h1000, 0, 1, 32'h1010, 0, 32'h1004);
    upd(32'h1000, 0, 1, 32'h1020, 1, 32'h1010);
    n_vec++; if (mispredict !== 1'b1) begin n_bad++; $display("FAIL tgt_mis got %0h exp 1", mispredict); end
    n_vec++; if (redirectPC !== 32'h1020) begin n_bad++; $display("FAIL tgt_redir got %0h exp 1020", redirectPC); end
    look(32'h1000);
    n_vec++; if (predTarget !== 32'h1020) begin n_bad++; $display("FAIL tgt_ptgt got %0h exp 1020", predTarget); end
    idle();
    n_vec++; if (mispredict !== 1'b0) begin n_bad++; $display("FAIL idle_mis got %0h exp 0", mispredict); end
    n_vec++; if (redirectPC !== 32'h1020) begin n_bad++; $display("FAIL idle_redir got %0h exp 1020", redirectPC); end
    upd(32'h1000, 0, 1, 32'h1020, 1, 32'h1020);
    n_vec++; if (mispredict !== 1'b0) begin n_bad++; $display("FAIL ok_mis got %0h exp 0", mispredict); end
    n_vec++; if (mispredictCount !== 4'd2) begin n_bad++; $display("FAIL ok_mcnt got %0d exp 2", mispredictCount); end
  endtask

  task automatic test_saturation();
    reset_dut();
    upd(32'h4000, 0, 1, 32'h4100, 0, 32'h4004);
    for (int i = 0; i < 20; i++) upd(32'h6000, 0, 0, 32'h0, 1, 32'h6100);
    n_vec++; if (branchCount !== 4'd15) begin n_bad++; $display("FAIL sat_bcnt got %0d exp 15", branchCount); end
    n_vec++; if (mispredictCount !== 4'd15) begin n_bad++; $display("FAIL sat_mcnt got %0d exp 15", mispredictCount); end
    @(negedge clk);
    rst = 1; updValid = 1; updPC = 32'h5000; updIsJump = 1; updTaken = 1; updTarget = 32'h7000;
    updPredTaken = 0; updPredTarget = 32'h5004;
    @(posedge clk); #1; rst = 0; updValid = 0;
    n_vec++; if (branchCount !== 4'd0) begin n_bad++; $display("FAIL rst2_bcnt got %0d exp 0", branchCount); end
    n_vec++; if (mispredictCount !== 4'd0) begin n_bad++; $display("FAIL rst2_mcnt got %0d exp 0", mispredictCount); end
    n_vec++; if (mispredict !== 1'b0) begin n_bad++; $display("FAIL rst2_mis got %0h exp 0", mispredict); end
    look(32'h4000);
    n_vec++; if (predTaken !== 1'b0) begin n_bad++; $display("FAIL rst2_pt4 got %0h exp 0", predTaken); end
    look(32'h5000);
    n_vec++; if (predTaken !== 1'b0) begin n_bad++; $display("FAIL rst2_pt5 got %0h exp 0", predTaken); end
    idle();
    look(32'h5000);
    n_vec++; if (predTaken !== 1'b0) begin n_bad++; $display("FAIL post_pt5 got %0h exp 0", predTaken); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_jump_alias();
    test_target_mis();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
